// File: rtl/rect_fill_renderer.sv
// rect_fill_renderer: queues rectangle commands, optionally clears the back buffer,
// then rasterizes each rectangle row-major as a stream of pixel writes.
module rect_fill_renderer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int FIFO_DEPTH = 4,
  parameter logic [2:0] BG_COLOR = 3'b000,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x0,
  input  logic [8:0] cmd_y0,
  input  logic [9:0] cmd_x1,
  input  logic [8:0] cmd_y1,
  input  logic [2:0] cmd_color,
  input  logic       cmd_last,
  output logic       px_valid,
  input  logic       px_ready,
  output logic [9:0] px_x,
  output logic [8:0] px_y,
  output logic [2:0] px_color,
  output logic       render_done,
  input  logic       render_ack,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] XMAX = 10'(H_RES - 1);
  localparam logic [8:0] YMAX = 9'(V_RES - 1);
  typedef enum logic [1:0] {S_CLEAR, S_FETCH, S_DRAW, S_DONE} state_t;
  localparam state_t S_INIT = CLEAR_EN ? S_CLEAR : S_FETCH;
  state_t r_state, w_next;
  logic [41:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_full, w_empty, w_push, w_pop;
  logic [9:0] w_hx0, w_hx1, w_x1c;
  logic [8:0] w_hy0, w_hy1, w_y1c;
  logic [2:0] w_hcol;
  logic w_hlast, w_blank;
  logic [9:0] r_x0, r_x1, r_px_x;
  logic [8:0] r_y1, r_px_y;
  logic [2:0] r_px_color;
  logic r_last, r_px_valid, r_done;
  logic w_fire, w_row_end, w_at_end, w_sweep;

  assign w_full = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
  assign w_empty = r_wr == r_rd;
  assign w_push = cmd_valid && !w_full;
  assign w_pop = r_state == S_FETCH && !w_empty;
  assign {w_hx0, w_hy0, w_hx1, w_hy1, w_hcol, w_hlast} = r_mem[r_rd[AW-1:0]];
  assign w_x1c = w_hx1 > XMAX ? XMAX : w_hx1;
  assign w_y1c = w_hy1 > YMAX ? YMAX : w_hy1;
  // an origin beyond the screen always exceeds the clamped far edge
  assign w_blank = w_hx0 > w_x1c || w_hy0 > w_y1c;
  assign w_fire = r_px_valid && px_ready;
  assign w_row_end = r_px_x == r_x1;
  assign w_at_end = w_row_end && r_px_y == r_y1;
  assign w_sweep = (r_state == S_CLEAR && !r_px_valid) || (CLEAR_EN && r_state == S_DONE && render_ack);

  assign cmd_ready = !w_full;
  assign px_valid = r_px_valid;
  assign px_x = r_px_x;
  assign px_y = r_px_y;
  assign px_color = r_px_color;
  assign render_done = r_done;
  assign busy = r_state != S_DONE;

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_last};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    r_state <= Reset ? S_INIT : w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CLEAR: w_next = w_fire && w_at_end ? S_FETCH : S_CLEAR;
      S_FETCH: w_next = w_empty ? S_FETCH : !w_blank ? S_DRAW : w_hlast ? S_DONE : S_FETCH;
      S_DRAW:  w_next = w_fire && w_at_end ? (r_last ? S_DONE : S_FETCH) : S_DRAW;
      S_DONE:  w_next = render_ack ? S_INIT : S_DONE;
      default: w_next = S_INIT;
    endcase
  end

  // the clear sweep reuses the rectangle walker with a full-screen window
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_px_valid <= 1'b0;
      r_px_x <= '0;
      r_px_y <= '0;
      r_px_color <= '0;
      r_done <= 1'b0;
      r_x0 <= '0;
      r_x1 <= XMAX;
      r_y1 <= YMAX;
      r_last <= 1'b0;
    end else begin
      r_done <= w_next == S_DONE;
      if (w_sweep) begin
        r_px_valid <= 1'b1;
        r_px_x <= '0;
        r_px_y <= '0;
        r_px_color <= BG_COLOR;
        r_x0 <= '0;
        r_x1 <= XMAX;
        r_y1 <= YMAX;
        r_last <= 1'b0;
      end else if (w_pop) begin
        r_px_valid <= !w_blank;
        r_px_x <= w_hx0;
        r_px_y <= w_hy0;
        r_px_color <= w_hcol;
        r_x0 <= w_hx0;
        r_x1 <= w_x1c;
        r_y1 <= w_y1c;
        r_last <= w_hlast;
      end else if (w_fire) begin
        if (w_at_end) r_px_valid <= 1'b0;
        else begin
          r_px_x <= w_row_end ? r_x0 : r_px_x + 10'd1;
          if (w_row_end) r_px_y <= r_px_y + 9'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rect_fill_renderer.sv
// tb_rect_fill_renderer: directed tests on a small-screen clearing instance and a
// full-screen instance with the clear sweep disabled.
module tb_rect_fill_renderer;
  localparam logic [2:0] BG = 3'b011;
  logic Clk = 0, Reset = 1;
  logic [9:0] cmd_x0 = 0, cmd_x1 = 0;
  logic [8:0] cmd_y0 = 0, cmd_y1 = 0;
  logic [2:0] cmd_color = 0;
  logic cmd_last = 0, a_cv = 0, b_cv = 0, px_ready = 0, render_ack = 0;
  logic a_cmd_ready, a_px_valid, a_done, a_busy, b_cmd_ready, b_px_valid, b_done, b_busy;
  logic [9:0] a_px_x, b_px_x;
  logic [8:0] a_px_y, b_px_y;
  logic [2:0] a_px_color, b_px_color;
  logic mon_sel = 0, mon_v;
  logic [9:0] mon_x;
  logic [8:0] mon_y;
  logic [2:0] mon_c;
  int total = 0, bad = 0;
  int qx[$], qy[$], qc[$], qt[$];

  always #10 Clk = ~Clk;

  rect_fill_renderer #(.H_RES(16), .V_RES(8), .FIFO_DEPTH(4), .BG_COLOR(BG), .CLEAR_EN(1'b1)) u_a (
    .Clk(Clk), .Reset(Reset), .cmd_valid(a_cv), .cmd_ready(a_cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_last(cmd_last), .px_valid(a_px_valid), .px_ready(px_ready),
    .px_x(a_px_x), .px_y(a_px_y), .px_color(a_px_color), .render_done(a_done),
    .render_ack(render_ack), .busy(a_busy));

  rect_fill_renderer #(.H_RES(640), .V_RES(480), .FIFO_DEPTH(4), .BG_COLOR(3'b000), .CLEAR_EN(1'b0)) u_b (
    .Clk(Clk), .Reset(Reset), .cmd_valid(b_cv), .cmd_ready(b_cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .cmd_last(cmd_last), .px_valid(b_px_valid), .px_ready(px_ready),
    .px_x(b_px_x), .px_y(b_px_y), .px_color(b_px_color), .render_done(b_done),
    .render_ack(render_ack), .busy(b_busy));

  assign mon_v = mon_sel ? b_px_valid : a_px_valid;
  assign mon_x = mon_sel ? b_px_x : a_px_x;
  assign mon_y = mon_sel ? b_px_y : a_px_y;
  assign mon_c = mon_sel ? b_px_color : a_px_color;

  task automatic push(input bit sel, input int x0, input int y0, input int x1, input int y1,
                      input int col, input bit last);
    int w = 0;
    @(negedge Clk);
    cmd_x0 = 10'(x0); cmd_y0 = 9'(y0); cmd_x1 = 10'(x1); cmd_y1 = 9'(y1);
    cmd_color = 3'(col); cmd_last = last;
    if (sel) b_cv = 1; else a_cv = 1;
    while (!(sel ? b_cmd_ready : a_cmd_ready) && w < 50) begin
      @(negedge Clk);
      w++;
    end
    @(negedge Clk);
    a_cv = 0; b_cv = 0;
    total++;
    if (w >= 50) begin bad++; $display("FAIL push_accept: waited %0d cycles, limit 50", w); end
  endtask

  task automatic collect(input int n, input int budget);
    qx.delete(); qy.delete(); qc.delete(); qt.delete();
    for (int i = 0; i < budget && qx.size() < n; i++) begin
      @(negedge Clk);
      px_ready = 1;
      if (mon_v) begin
        qx.push_back(int'(mon_x)); qy.push_back(int'(mon_y));
        qc.push_back(int'(mon_c)); qt.push_back(i);
      end
    end
    @(posedge Clk);
    #1 px_ready = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    repeat (2) @(negedge Clk);
    total++;
    if ({a_px_valid, a_px_x, a_px_y, a_px_color} !== 23'd0) begin
      bad++; $display("FAIL reset_px: got v=%b x=%0d y=%0d c=%0d want all 0", a_px_valid, a_px_x, a_px_y, a_px_color);
    end
    total++;
    if ({a_done, a_busy, a_cmd_ready} !== 3'b011) begin
      bad++; $display("FAIL reset_ctl: got done/busy/ready=%b want 011", {a_done, a_busy, a_cmd_ready});
    end
    total++;
    if ({b_px_valid, b_done, b_busy, b_cmd_ready} !== 4'b0011) begin
      bad++; $display("FAIL reset_b: got %b want 0011", {b_px_valid, b_done, b_busy, b_cmd_ready});
    end
    Reset = 0;
    @(negedge Clk);
    total++;
    if ({a_px_valid, a_px_x, a_px_y, a_px_color} !== {1'b1, 10'd0, 9'd0, BG}) begin
      bad++; $display("FAIL sweep_start: got v=%b x=%0d y=%0d c=%0d want 1,0,0,%0d", a_px_valid, a_px_x, a_px_y, a_px_color, BG);
    end
  endtask

  task automatic test_frame();
    int e;
    push(0, 10, 2, 12, 3, 5, 1);
    mon_sel = 0;
    collect(134, 400);
    total++;
    if (qx.size() !== 134) begin bad++; $display("FAIL frame_count: got %0d want 134", qx.size()); end
    e = -1;
    for (int i = 0; i < 128 && i < qx.size(); i++)
      if (e < 0 && (qx[i] !== i % 16 || qy[i] !== i / 16 || qc[i] !== int'(BG))) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL clear_seq: idx %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", e, qx[e], qy[e], qc[e], e % 16, e / 16, BG);
    end
    e = -1;
    for (int i = 0; i < 6 && 128 + i < qx.size(); i++)
      if (e < 0 && (qx[128+i] !== 10 + i % 3 || qy[128+i] !== 2 + i / 3 || qc[128+i] !== 5)) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL rect_seq: idx %0d got (%0d,%0d,%0d) want (%0d,%0d,5)", e, qx[128+e], qy[128+e], qc[128+e], 10 + e % 3, 2 + e / 3);
    end
    @(negedge Clk);
    total++;
    if ({a_done, a_busy, a_px_valid} !== 3'b100) begin
      bad++; $display("FAIL done_state: got done/busy/valid=%b want 100", {a_done, a_busy, a_px_valid});
    end
    repeat (5) @(negedge Clk);
    total++;
    if (a_done !== 1'b1) begin bad++; $display("FAIL done_hold: got %b want 1", a_done); end
    render_ack = 1;
    @(negedge Clk);
    render_ack = 0;
    total++;
    if ({a_done, a_px_valid, a_px_x, a_px_y, a_px_color} !== {1'b0, 1'b1, 10'd0, 9'd0, BG}) begin
      bad++; $display("FAIL ack_restart: got done=%b v=%b x=%0d y=%0d c=%0d want 0,1,0,0,%0d", a_done, a_px_valid, a_px_x, a_px_y, a_px_color, BG);
    end
  endtask

  task automatic test_back_to_back();
    int cx0[5] = '{0, 2, 5, 14, 3};
    int cy0[5] = '{0, 1, 5, 6, 3};
    int cx1[5] = '{1, 2, 4, 20, 3};
    int cy1[5] = '{0, 1, 7, 9, 4};
    int ccl[5] = '{1, 2, 3, 4, 6};
    int ex[9] = '{0, 1, 2, 14, 15, 14, 15, 3, 3};
    int ey[9] = '{0, 0, 1, 6, 6, 7, 7, 3, 4};
    int ec[9] = '{1, 1, 2, 4, 4, 4, 4, 6, 6};
    int acc_at = -1, e;
    for (int k = 0; k < 5; k++) begin
      cmd_x0 = 10'(cx0[k]); cmd_y0 = 9'(cy0[k]); cmd_x1 = 10'(cx1[k]); cmd_y1 = 9'(cy1[k]);
      cmd_color = 3'(ccl[k]); cmd_last = (k == 4); a_cv = 1;
      total++;
      if (a_cmd_ready !== (k < 4)) begin
        bad++; $display("FAIL fifo_ready_%0d: got %b want %b", k, a_cmd_ready, k < 4);
      end
      @(negedge Clk);
    end
    qx.delete(); qy.delete(); qc.delete();
    for (int i = 0; i < 400 && qx.size() < 137; i++) begin
      if (acc_at >= 0) a_cv = 0;
      else if (a_cmd_ready) acc_at = qx.size();
      px_ready = 1;
      if (a_px_valid) begin
        qx.push_back(int'(a_px_x)); qy.push_back(int'(a_px_y)); qc.push_back(int'(a_px_color));
      end
      @(negedge Clk);
    end
    px_ready = 0; a_cv = 0;
    total++;
    if (acc_at !== 128) begin bad++; $display("FAIL fifth_accept: got after %0d pixels want 128", acc_at); end
    total++;
    if (qx.size() !== 137) begin bad++; $display("FAIL b2b_count: got %0d want 137", qx.size()); end
    e = -1;
    for (int i = 0; i < 9 && 128 + i < qx.size(); i++)
      if (e < 0 && (qx[128+i] !== ex[i] || qy[128+i] !== ey[i] || qc[128+i] !== ec[i])) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL b2b_seq: idx %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", e, qx[128+e], qy[128+e], qc[128+e], ex[e], ey[e], ec[e]);
    end
    total++;
    if (a_done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", a_done); end
    render_ack = 1;
    @(negedge Clk);
    render_ack = 0;
  endtask

  task automatic test_stall();
    int e, stab = 0;
    logic prev_stall = 0;
    logic [9:0] px;
    logic [8:0] py;
    logic [2:0] pc;
    push(0, 0, 0, 3, 3, 7, 1);
    qx.delete(); qy.delete(); qc.delete();
    for (int i = 0; i < 1500 && qx.size() < 144; i++) begin
      @(negedge Clk);
      if (prev_stall && (!a_px_valid || a_px_x !== px || a_px_y !== py || a_px_color !== pc)) stab++;
      px_ready = 1'($urandom_range(0, 1));
      render_ack = qx.size() >= 128 ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_stall = a_px_valid && !px_ready;
      px = a_px_x; py = a_px_y; pc = a_px_color;
      if (a_px_valid && px_ready) begin
        qx.push_back(int'(a_px_x)); qy.push_back(int'(a_px_y)); qc.push_back(int'(a_px_color));
      end
    end
    @(posedge Clk);
    #1 px_ready = 0; render_ack = 0;
    @(negedge Clk);
    total++;
    if (qx.size() !== 144) begin bad++; $display("FAIL stall_count: got %0d want 144", qx.size()); end
    total++;
    if (stab !== 0) begin bad++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stab); end
    e = -1;
    for (int i = 0; i < 128 && i < qx.size(); i++)
      if (e < 0 && (qx[i] !== i % 16 || qy[i] !== i / 16 || qc[i] !== int'(BG))) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL stall_clear: idx %0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)", e, qx[e], qy[e], qc[e], e % 16, e / 16, BG);
    end
    e = -1;
    for (int i = 0; i < 16 && 128 + i < qx.size(); i++)
      if (e < 0 && (qx[128+i] !== i % 4 || qy[128+i] !== i / 4 || qc[128+i] !== 7)) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL stall_rect: idx %0d got (%0d,%0d,%0d) want (%0d,%0d,7)", e, qx[128+e], qy[128+e], qc[128+e], e % 4, e / 4);
    end
    total++;
    if ({a_done, a_busy} !== 2'b10) begin
      bad++; $display("FAIL early_ack: got done/busy=%b want 10", {a_done, a_busy});
    end
    render_ack = 1;
    @(negedge Clk);
    render_ack = 0;
  endtask

  task automatic test_reset_mid_draw();
    push(0, 0, 0, 7, 1, 1, 0);
    push(0, 1, 1, 2, 2, 2, 0);
    push(0, 3, 3, 4, 4, 3, 0);
    mon_sel = 0;
    collect(131, 400);
    @(negedge Clk);
    total++;
    if ({a_px_valid, a_px_x, a_px_y} !== {1'b1, 10'd3, 9'd0}) begin
      bad++; $display("FAIL mid_draw: got v=%b x=%0d y=%0d want 1,3,0", a_px_valid, a_px_x, a_px_y);
    end
    Reset = 1;
    @(negedge Clk);
    total++;
    if ({a_px_valid, a_px_x, a_px_y, a_px_color, a_done, a_busy, a_cmd_ready} !== {23'd0, 3'b011}) begin
      bad++; $display("FAIL mid_reset: got v=%b x=%0d y=%0d done/busy/ready=%b want 0,0,0,011", a_px_valid, a_px_x, a_px_y, {a_done, a_busy, a_cmd_ready});
    end
    Reset = 0;
    for (int k = 0; k < 4; k++) begin
      cmd_x0 = 10'(k); cmd_y0 = 0; cmd_x1 = 10'(k); cmd_y1 = 0; cmd_color = 1; cmd_last = 0; a_cv = 1;
      total++;
      if (a_cmd_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_%0d: got %b want 1", k, a_cmd_ready); end
      @(negedge Clk);
    end
    a_cv = 0;
    total++;
    if (a_cmd_ready !== 1'b0) begin bad++; $display("FAIL flush_full: got %b want 0", a_cmd_ready); end
    collect(1, 10);
    total++;
    if (qx.size() !== 1 || qx[0] !== 0 || qy[0] !== 0 || qc[0] !== int'(BG)) begin
      bad++; $display("FAIL reset_sweep: got n=%0d (%0d,%0d,%0d) want 1 (0,0,%0d)", qx.size(), qx[0], qy[0], qc[0], BG);
    end
  endtask

  task automatic test_clamp_no_clear();
    int e;
    mon_sel = 1;
    total++;
    if ({b_px_valid, b_busy} !== 2'b01) begin
      bad++; $display("FAIL no_clear_idle: got valid/busy=%b want 01", {b_px_valid, b_busy});
    end
    push(1, 630, 470, 700, 500, 2, 0);
    push(1, 5, 5, 4, 9, 3, 0);
    push(1, 100, 200, 101, 200, 4, 1);
    collect(102, 400);
    total++;
    if (qx.size() !== 102) begin bad++; $display("FAIL clamp_count: got %0d want 102", qx.size()); end
    e = -1;
    for (int i = 0; i < 100 && i < qx.size(); i++)
      if (e < 0 && (qx[i] !== 630 + i % 10 || qy[i] !== 470 + i / 10 || qc[i] !== 2)) e = i;
    total++;
    if (e >= 0) begin
      bad++; $display("FAIL clamp_seq: idx %0d got (%0d,%0d,%0d) want (%0d,%0d,2)", e, qx[e], qy[e], qc[e], 630 + e % 10, 470 + e / 10);
    end
    total++;
    if (qx.size() < 102 || qx[100] !== 100 || qx[101] !== 101 || qy[100] !== 200 || qy[101] !== 200 || qc[100] !== 4 || qc[101] !== 4) begin
      bad++; $display("FAIL after_empty_seq: got n=%0d want (100,200,4),(101,200,4) after the clamped rectangle", qx.size());
    end
    total++;
    if (qt.size() < 101 || qt[100] - qt[99] !== 3) begin
      bad++; $display("FAIL empty_gap: got %0d cycles want 3", qt.size() < 101 ? -1 : qt[100] - qt[99]);
    end
    @(negedge Clk);
    total++;
    if ({b_done, b_busy, b_px_valid} !== 3'b100) begin
      bad++; $display("FAIL b_done: got done/busy/valid=%b want 100", {b_done, b_busy, b_px_valid});
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_stall();
    test_reset_mid_draw();
    test_clamp_no_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
